id_ex_operand_stage: RTL

//  ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.

---
 rtl/id_ex_operand_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand bypassing and load-use hazard detection.
// Drives the ALU operands, the ALU operation, store data and destination info toward EX/MEM.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_srca_pc,
  input  logic                     id_srcb_imm,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic                     hazard_stall
);

  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic [REG_ADDR_W-1:0]    r_rs1;
  logic [REG_ADDR_W-1:0]    r_rs2;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic [REG_ADDR_W-1:0]    r_rd;
  logic [OPCODE_LENGTH-1:0] r_alu_op;
  logic                     r_srca_pc;
  logic                     r_srcb_imm;
  logic                     r_reg_write;
  logic                     r_mem_read;

  logic [DATA_WIDTH-1:0]    w_fwd_a;
  logic [DATA_WIDTH-1:0]    w_fwd_b;
  logic                     w_bubble;

  // EX/MEM is the newer producer, so it is checked before MEM/WB.
  always_comb begin
    w_fwd_a = r_rs1_data;
    if (r_rs1 == '0)
      w_fwd_a = '0;
    else if (exmem_reg_write && (exmem_rd == r_rs1))
      w_fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd == r_rs1))
      w_fwd_a = memwb_result;
  end

  always_comb begin
    w_fwd_b = r_rs2_data;
    if (r_rs2 == '0)
      w_fwd_b = '0;
    else if (exmem_reg_write && (exmem_rd == r_rs2))
      w_fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd == r_rs2))
      w_fwd_b = memwb_result;
  end

  assign hazard_stall = !reset && r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                        ((r_rd == id_rs1) || (r_rd == id_rs2));

  assign w_bubble = flush || hazard_stall || !id_valid;

  // A stalled stage keeps re-capturing its bypassed operands so a producer retiring mid-stall is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_alu_op    <= '0;
      r_srca_pc   <= 1'b0;
      r_srcb_imm  <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (stall && !flush) begin
      r_rs1_data <= w_fwd_a;
      r_rs2_data <= w_fwd_b;
    end else begin
      r_pc       <= id_pc;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_srca_pc  <= id_srca_pc;
      r_srcb_imm <= id_srcb_imm;
      if (w_bubble) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_alu_op    <= '0;
        r_rd        <= '0;
      end else begin
        r_valid     <= 1'b1;
        r_reg_write <= id_reg_write;
        r_mem_read  <= id_mem_read;
        r_alu_op    <= id_alu_op;
        r_rd        <= id_rd;
      end
    end
  end

  assign SrcA          = r_srca_pc  ? r_pc  : w_fwd_a;
  assign SrcB          = r_srcb_imm ? r_imm : w_fwd_b;
  assign ex_store_data = w_fwd_b;
  assign Operation     = r_alu_op;
  assign ex_valid      = r_valid;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_pc         = r_pc;

endmodule
